// File: rtl/vid_io_pkg.sv
// Shared video-timing constants, TX FSM state encoding and {R,B,G} colour-bar palette.
package vid_io_pkg;

  localparam int unsigned CNT_W = 12;

  localparam int unsigned T1080_H_ACTIVE = 1920;
  localparam int unsigned T1080_H_FP     = 88;
  localparam int unsigned T1080_H_SYNC   = 44;
  localparam int unsigned T1080_H_BP     = 148;
  localparam int unsigned T1080_V_ACTIVE = 1080;
  localparam int unsigned T1080_V_FP     = 4;
  localparam int unsigned T1080_V_SYNC   = 5;
  localparam int unsigned T1080_V_BP     = 36;
  localparam int unsigned T1080_H_TOTAL  = T1080_H_ACTIVE + T1080_H_FP + T1080_H_SYNC + T1080_H_BP;
  localparam int unsigned T1080_V_TOTAL  = T1080_V_ACTIVE + T1080_V_FP + T1080_V_SYNC + T1080_V_BP;

  localparam int unsigned T720_H_ACTIVE  = 1280;
  localparam int unsigned T720_H_FP      = 110;
  localparam int unsigned T720_H_SYNC    = 40;
  localparam int unsigned T720_H_BP      = 220;
  localparam int unsigned T720_V_ACTIVE  = 720;
  localparam int unsigned T720_V_FP      = 5;
  localparam int unsigned T720_V_SYNC    = 5;
  localparam int unsigned T720_V_BP      = 20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } tx_state_t;

  // Full-scale colours packed as {R,B,G}
  localparam logic [23:0] RBG_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RBG_YELLOW  = 24'hFF00FF;
  localparam logic [23:0] RBG_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RBG_GREEN   = 24'h0000FF;
  localparam logic [23:0] RBG_MAGENTA = 24'hFFFF00;
  localparam logic [23:0] RBG_RED     = 24'hFF0000;
  localparam logic [23:0] RBG_BLUE    = 24'h00FF00;
  localparam logic [23:0] RBG_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = RBG_WHITE;
      3'd1:    c = RBG_YELLOW;
      3'd2:    c = RBG_CYAN;
      3'd3:    c = RBG_GREEN;
      3'd4:    c = RBG_MAGENTA;
      3'd5:    c = RBG_RED;
      3'd6:    c = RBG_BLUE;
      default: c = RBG_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vid_tx_counter.sv
// Raster h/v counters with wrap, region flags and end-of-frame strobe; 0-clk flags from counters.
// Counters are held at zero while i_run is low; there is no backpressure.
module vid_tx_counter
  import vid_io_pkg::*;
#(
  parameter int unsigned H_ACTIVE = T1080_H_ACTIVE,
  parameter int unsigned H_FP     = T1080_H_FP,
  parameter int unsigned H_SYNC   = T1080_H_SYNC,
  parameter int unsigned H_BP     = T1080_H_BP,
  parameter int unsigned V_ACTIVE = T1080_V_ACTIVE,
  parameter int unsigned V_FP     = T1080_V_FP,
  parameter int unsigned V_SYNC   = T1080_V_SYNC,
  parameter int unsigned V_BP     = T1080_V_BP
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_run,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_h_act,
  output logic             o_v_act,
  output logic             o_h_sync,
  output logic             o_v_sync,
  output logic             o_eof
);

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;
  assign o_h_act  = (r_h_cnt < H_ACT_END);
  assign o_v_act  = (r_v_cnt < V_ACT_END);
  assign o_h_sync = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign o_v_sync = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
  assign o_eof    = w_h_wrap && w_v_wrap;

endmodule

// File: rtl/vid_timing_tx.sv
// vid_io raster transmitter: counters -> outputs in 2 clks, pixel fetched with 1-clk read latency.
// No backpressure; VID_TX_TEST_PATTERN_EN adds an 8-bar colour pattern selected by sw[3].
module vid_timing_tx
  import vid_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned H_ACTIVE   = T1080_H_ACTIVE,
  parameter int unsigned H_FP       = T1080_H_FP,
  parameter int unsigned H_SYNC     = T1080_H_SYNC,
  parameter int unsigned H_BP       = T1080_H_BP,
  parameter int unsigned V_ACTIVE   = T1080_V_ACTIVE,
  parameter int unsigned V_FP       = T1080_V_FP,
  parameter int unsigned V_SYNC     = T1080_V_SYNC,
  parameter int unsigned V_BP       = T1080_V_BP
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_en,
  output logic                  o_pix_req,
  output logic [10:0]           o_pix_addr,
  output logic [10:0]           o_pix_line,
  input  logic [DATA_WIDTH-1:0] i_pix_data,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  output logic                  o_sof,
  input  logic [3:0]            sw
);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic             w_run;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_act, w_v_act, w_h_sync, w_v_sync, w_eof;
  logic             w_active;
  logic             r_s1_de, r_s1_hs, r_s1_vs, r_s1_sof;
  logic [DATA_WIDTH-1:0] w_pix_src;
  logic             w_unused;

  vid_tx_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_run    (w_run),
    .o_h_cnt  (w_h_cnt),
    .o_v_cnt  (w_v_cnt),
    .o_h_act  (w_h_act),
    .o_v_act  (w_v_act),
    .o_h_sync (w_h_sync),
    .o_v_sync (w_v_sync),
    .o_eof    (w_eof)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A frame in progress always runs to its end; re-enabling while stopping is seamless.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:     if (i_en) w_state_nxt = ST_RUN;
      ST_RUN:      if (!i_en) w_state_nxt = w_eof ? ST_IDLE : ST_STOPPING;
      ST_STOPPING: begin
        if (i_en)       w_state_nxt = ST_RUN;
        else if (w_eof) w_state_nxt = ST_IDLE;
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_active   = w_run && w_h_act && w_v_act;
  assign o_pix_req  = w_active;
  assign o_pix_addr = w_active ? w_h_cnt[10:0] : 11'd0;
  assign o_pix_line = w_active ? w_v_cnt[10:0] : 11'd0;

`ifdef VID_TX_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [CNT_W-1:0] r_bar_pos;
  logic [2:0]       r_bar_idx;
  logic [2:0]       r_s1_bar;

  // Bar index tracks h_cnt by counting pixels; the last bar keeps any remainder.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bar_pos <= '0;
      r_bar_idx <= '0;
      r_s1_bar  <= '0;
    end else begin
      r_s1_bar <= r_bar_idx;
      if (!w_active) begin
        r_bar_pos <= '0;
        r_bar_idx <= '0;
      end else if ((r_bar_pos == CNT_W'(BAR_W - 1)) && (r_bar_idx != 3'd7)) begin
        r_bar_pos <= '0;
        r_bar_idx <= r_bar_idx + 1'b1;
      end else begin
        r_bar_pos <= r_bar_pos + 1'b1;
      end
    end
  end

  assign w_pix_src = sw[3] ? DATA_WIDTH'(bar_colour(r_s1_bar)) : i_pix_data;
  assign w_unused  = ^{sw[2:0], w_h_cnt[11], w_v_cnt[11]};
`else
  assign w_pix_src = i_pix_data;
  assign w_unused  = ^{sw, w_h_cnt[11], w_v_cnt[11]};
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1_de     <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_sof    <= 1'b0;
      o_vid_VDE   <= 1'b0;
      o_vid_hsync <= 1'b0;
      o_vid_vsync <= 1'b0;
      o_sof       <= 1'b0;
      o_vid_data  <= '0;
    end else begin
      r_s1_de     <= w_active;
      r_s1_hs     <= w_run && w_h_sync;
      r_s1_vs     <= w_run && w_v_sync;
      r_s1_sof    <= w_active && (w_h_cnt == '0) && (w_v_cnt == '0);
      o_vid_VDE   <= r_s1_de;
      o_vid_hsync <= r_s1_hs;
      o_vid_vsync <= r_s1_vs;
      o_sof       <= r_s1_sof;
      o_vid_data  <= r_s1_de ? w_pix_src : '0;
    end
  end

endmodule
